// File: rtl/sub_acc_i8_if.sv
// Handshake bundle between the LUT subtractor difference stream and the batch
// accumulator result stream.
// Ports: y/y_valid/y_ready carry samples in, sum/ovf/sum_valid/sum_ready carry
// batch results out. The slave modport is the accumulator's view; the master
// modport is the producer of y and the consumer of sum.
interface sub_acc_i8_if;
  logic [7:0] y;
  logic       y_valid;
  logic       y_ready;
  logic [7:0] sum;
  logic       ovf;
  logic       sum_valid;
  logic       sum_ready;

  modport master (
    output y,
    output y_valid,
    input  y_ready,
    input  sum,
    input  ovf,
    input  sum_valid,
    output sum_ready
  );

  modport slave (
    input  y,
    input  y_valid,
    output y_ready,
    output sum,
    output ovf,
    output sum_valid,
    input  sum_ready
  );
endinterface

// File: rtl/sub_acc_i8.sv
// Batch accumulator: sums COUNT signed 8-bit samples (wrapping) and flags any
// signed overflow seen during the batch; result is registered (1 cycle after
// the last accept). A held result stalls the input port until it is taken.
// Ports: clock, reset (sync, active-high), clear (sync batch abort), bus
// (slave modport: y/y_valid/y_ready in, sum/ovf/sum_valid/sum_ready out).
module sub_acc_i8 #(
  parameter int COUNT = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  sub_acc_i8_if.slave  bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  // Count value at which the next accept completes the batch.
  localparam logic [7:0] CNT_LAST = 8'(COUNT - 1);

  logic [1:0] state_q, state_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] cnt_q, cnt_d;
  logic       ovf_q, ovf_d;

  logic       accept;
  logic [7:0] acc_sum;
  logic       add_ovf;

  // y_ready is a pure decode of the state register, so accept never feeds
  // back into the ready it depends on.
  assign accept  = bus.y_valid && (state_q == ST_ACCUM);
  assign acc_sum = acc_q + bus.y;
  // Signed overflow: both operands share a sign and the result's sign differs.
  assign add_ovf = (acc_q[7] == bus.y[7]) && (acc_sum[7] != acc_q[7]);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        // Leaving reset: start a fresh batch; clear has nothing to abort yet.
        state_d = ST_ACCUM;
        acc_d   = 8'd0;
        cnt_d   = 8'd0;
        ovf_d   = 1'b0;
      end
      ST_ACCUM: begin
        if (clear) begin
          // A sample handshaken alongside clear is dropped with the batch.
          acc_d = 8'd0;
          cnt_d = 8'd0;
          ovf_d = 1'b0;
        end else if (accept) begin
          acc_d = acc_sum;
          cnt_d = cnt_q + 8'd1;
          ovf_d = ovf_q | add_ovf;
          if (cnt_q == CNT_LAST) begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        // Clear and a result handshake both end in an empty ACCUM; clear
        // simply discards the result instead of delivering it.
        if (clear || bus.sum_ready) begin
          state_d = ST_ACCUM;
          acc_d   = 8'd0;
          cnt_d   = 8'd0;
          ovf_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_ACCUM;
        acc_d   = 8'd0;
        cnt_d   = 8'd0;
        ovf_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      acc_q   <= 8'd0;
      cnt_q   <= 8'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.y_ready   = (state_q == ST_ACCUM);
  assign bus.sum_valid = (state_q == ST_HOLD);
  assign bus.sum       = acc_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_sub_acc_i8.sv
// Bench for sub_acc_i8 (COUNT=4): directed scenarios plus a randomized run
// checked against a sample-queue reference model.
module tb_sub_acc_i8;

  localparam int COUNT = 4;

  logic clock = 1'b0;
  logic reset;
  logic clear;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clock = ~clock;

  sub_acc_i8_if bus ();

  sub_acc_i8 #(.COUNT(COUNT)) dut (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .bus   (bus.slave)
  );

  // Reference model: phase 0 = in/just out of reset, 1 = collecting, 2 = result held.
  int         m_phase = 0;
  logic [7:0] m_q[$];

  function automatic logic [7:0] q_sum();
    int s;
    s = 0;
    foreach (m_q[i]) s += int'(m_q[i]);
    return 8'(s);
  endfunction

  function automatic logic q_ovf();
    int   a;
    int   t;
    logic o;
    a = 0;
    o = 1'b0;
    foreach (m_q[i]) begin
      t = a + int'($signed(m_q[i]));
      if (t > 127 || t < -128) o = 1'b1;
      a = (t > 127) ? t - 256 : ((t < -128) ? t + 256 : t);
    end
    return o;
  endfunction

  function automatic void model_update();
    if (reset) begin
      m_phase = 0;
      m_q.delete();
    end else if (m_phase == 0) begin
      m_phase = 1;
    end else if (clear) begin
      m_phase = 1;
      m_q.delete();
    end else if (m_phase == 1 && bus.y_valid) begin
      m_q.push_back(bus.y);
      if (m_q.size() == COUNT) m_phase = 2;
    end else if (m_phase == 2 && bus.sum_ready) begin
      m_phase = 1;
      m_q.delete();
    end
  endfunction

  task automatic tick();
    model_update();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] v);
    bus.y_valid = 1'b1;
    bus.y       = v;
    tick();
    bus.y_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (16) tick();
    n_checks++; if (bus.y_ready !== 1'b0) begin n_fail++; $display("FAIL reset_y_ready: got %b want 0", bus.y_ready); end
    n_checks++; if (bus.sum_valid !== 1'b0) begin n_fail++; $display("FAIL reset_sum_valid: got %b want 0", bus.sum_valid); end
    n_checks++; if (bus.sum !== 8'h00) begin n_fail++; $display("FAIL reset_sum: got %h want 00", bus.sum); end
    n_checks++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", bus.ovf); end
    reset = 1'b0;
    n_checks++; if (bus.y_ready !== 1'b0) begin n_fail++; $display("FAIL reset_first_cycle_y_ready: got %b want 0", bus.y_ready); end
    tick();
    n_checks++; if (bus.y_ready !== 1'b1) begin n_fail++; $display("FAIL reset_second_cycle_y_ready: got %b want 1", bus.y_ready); end
  endtask

  task automatic test_basic();
    bus.sum_ready = 1'b1;
    repeat (4) send(8'd4);
    n_checks++; if (bus.sum_valid !== 1'b1) begin n_fail++; $display("FAIL basic_sum_valid: got %b want 1", bus.sum_valid); end
    n_checks++; if (bus.sum !== 8'd16) begin n_fail++; $display("FAIL basic_sum: got %0d want 16", bus.sum); end
    n_checks++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL basic_ovf: got %b want 0", bus.ovf); end
    n_checks++; if (bus.y_ready !== 1'b0) begin n_fail++; $display("FAIL basic_y_ready_hold: got %b want 0", bus.y_ready); end
    tick();
    n_checks++; if (bus.sum_valid !== 1'b0) begin n_fail++; $display("FAIL basic_sum_valid_after: got %b want 0", bus.sum_valid); end
    n_checks++; if (bus.y_ready !== 1'b1) begin n_fail++; $display("FAIL basic_y_ready_after: got %b want 1", bus.y_ready); end
  endtask

  task automatic test_wrap_ovf();
    bus.sum_ready = 1'b0;
    send(8'd100); send(8'd100); send(8'd0); send(8'd0);
    n_checks++; if (bus.sum !== 8'hC8) begin n_fail++; $display("FAIL wrap_sum: got %h want c8", bus.sum); end
    n_checks++; if (bus.ovf !== 1'b1) begin n_fail++; $display("FAIL wrap_ovf: got %b want 1", bus.ovf); end
    bus.sum_ready = 1'b1;
    tick();
    send(8'hFD); send(8'd1); send(8'd0); send(8'd0);
    n_checks++; if (bus.sum_valid !== 1'b1) begin n_fail++; $display("FAIL wrap2_sum_valid: got %b want 1", bus.sum_valid); end
    n_checks++; if (bus.sum !== 8'hFE) begin n_fail++; $display("FAIL wrap2_sum: got %h want fe", bus.sum); end
    n_checks++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL wrap2_ovf_sticky_cleared: got %b want 0", bus.ovf); end
    tick();
  endtask

  task automatic test_backpressure();
    bus.sum_ready = 1'b0;
    send(8'd10); send(8'd20); send(8'd30); send(8'd40);
    bus.y_valid = 1'b1;
    bus.y       = 8'd55;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (bus.sum_valid !== 1'b1) begin n_fail++; $display("FAIL bp_sum_valid[%0d]: got %b want 1", i, bus.sum_valid); end
      n_checks++; if (bus.sum !== 8'd100) begin n_fail++; $display("FAIL bp_sum[%0d]: got %0d want 100", i, bus.sum); end
      n_checks++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL bp_ovf[%0d]: got %b want 0", i, bus.ovf); end
      n_checks++; if (bus.y_ready !== 1'b0) begin n_fail++; $display("FAIL bp_y_ready[%0d]: got %b want 0", i, bus.y_ready); end
    end
    bus.sum_ready = 1'b1;
    tick();
    bus.y_valid = 1'b0;
    n_checks++; if (bus.sum_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_sum_valid: got %b want 0", bus.sum_valid); end
    n_checks++; if (bus.y_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_y_ready: got %b want 1", bus.y_ready); end
    send(8'd1); send(8'd2); send(8'd3); send(8'd4);
    n_checks++; if (bus.sum !== 8'd10) begin n_fail++; $display("FAIL bp_resume_sum: got %0d want 10", bus.sum); end
    tick();
  endtask

  task automatic test_gaps();
    logic [6:0] pat;
    int         k;
    pat = 7'b1101001;  // bit i is y_valid in cycle i: 1,0,0,1,0,1,1
    k   = 0;
    bus.sum_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.y_valid = pat[i];
      if (pat[i]) begin
        k++;
        bus.y = 8'(k);
      end else begin
        bus.y = 8'hEE;
      end
      tick();
      if (i == 5) begin
        n_checks++; if (bus.sum_valid !== 1'b0) begin n_fail++; $display("FAIL gaps_early_sum_valid: got %b want 0", bus.sum_valid); end
      end
    end
    bus.y_valid = 1'b0;
    n_checks++; if (bus.sum_valid !== 1'b1) begin n_fail++; $display("FAIL gaps_sum_valid: got %b want 1", bus.sum_valid); end
    n_checks++; if (bus.sum !== 8'd10) begin n_fail++; $display("FAIL gaps_sum: got %0d want 10", bus.sum); end
    tick();
  endtask

  task automatic test_clear();
    bus.sum_ready = 1'b1;
    send(8'd5); send(8'd6);
    clear = 1'b1; bus.y_valid = 1'b1; bus.y = 8'd7;
    tick();
    clear = 1'b0; bus.y_valid = 1'b0;
    n_checks++; if (bus.y_ready !== 1'b1) begin n_fail++; $display("FAIL clear_y_ready: got %b want 1", bus.y_ready); end
    repeat (4) send(8'd1);
    n_checks++; if (bus.sum_valid !== 1'b1) begin n_fail++; $display("FAIL clear_sum_valid: got %b want 1", bus.sum_valid); end
    n_checks++; if (bus.sum !== 8'd4) begin n_fail++; $display("FAIL clear_sum: got %0d want 4", bus.sum); end
    // Clear while a result is held drops it even with sum_ready high.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_checks++; if (bus.sum_valid !== 1'b0) begin n_fail++; $display("FAIL clear_hold_sum_valid: got %b want 0", bus.sum_valid); end
    repeat (4) send(8'd2);
    n_checks++; if (bus.sum !== 8'd8) begin n_fail++; $display("FAIL clear_hold_next_sum: got %0d want 8", bus.sum); end
    tick();
  endtask

  task automatic test_mid_reset();
    bus.sum_ready = 1'b1;
    send(8'd5); send(8'd6);
    reset = 1'b1; bus.y_valid = 1'b1; bus.y = 8'd7;
    tick();
    n_checks++; if (bus.y_ready !== 1'b0) begin n_fail++; $display("FAIL mreset_y_ready: got %b want 0", bus.y_ready); end
    n_checks++; if (bus.sum !== 8'd0) begin n_fail++; $display("FAIL mreset_sum: got %0d want 0", bus.sum); end
    reset = 1'b0; bus.y = 8'd1;
    repeat (4) tick();
    n_checks++; if (bus.sum_valid !== 1'b0) begin n_fail++; $display("FAIL mreset_early_sum_valid: got %b want 0", bus.sum_valid); end
    tick();
    bus.y_valid = 1'b0;
    n_checks++; if (bus.sum_valid !== 1'b1) begin n_fail++; $display("FAIL mreset_sum_valid: got %b want 1", bus.sum_valid); end
    n_checks++; if (bus.sum !== 8'd4) begin n_fail++; $display("FAIL mreset_sum: got %0d want 4", bus.sum); end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      bus.y         = 8'($urandom);
      bus.y_valid   = ($urandom_range(0, 9) < 6);
      bus.sum_ready = ($urandom_range(0, 1) == 1);
      clear         = ($urandom_range(0, 39) == 0);
      reset         = ($urandom_range(0, 149) == 0);
      tick();
      n_checks++; if (bus.y_ready !== (m_phase == 1)) begin n_fail++; $display("FAIL rand_y_ready[%0d]: got %b want %b", c, bus.y_ready, m_phase == 1); end
      n_checks++; if (bus.sum_valid !== (m_phase == 2)) begin n_fail++; $display("FAIL rand_sum_valid[%0d]: got %b want %b", c, bus.sum_valid, m_phase == 2); end
      if (m_phase != 1) begin
        n_checks++; if (bus.sum !== q_sum()) begin n_fail++; $display("FAIL rand_sum[%0d]: got %h want %h", c, bus.sum, q_sum()); end
        n_checks++; if (bus.ovf !== q_ovf()) begin n_fail++; $display("FAIL rand_ovf[%0d]: got %b want %b", c, bus.ovf, q_ovf()); end
      end
    end
    reset = 1'b0;
    clear = 1'b0;
    bus.y_valid = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    clear         = 1'b0;
    bus.y         = 8'd0;
    bus.y_valid   = 1'b0;
    bus.sum_ready = 1'b0;
    test_reset();
    test_basic();
    test_wrap_ovf();
    test_backpressure();
    test_gaps();
    test_clear();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
